// File: rtl/axi_ic_pkg.sv
// Shared types for the 2-master AXI4 interconnect: response codes and master select.
package axi_ic_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef logic master_sel_t;
  localparam master_sel_t MST_S00 = 1'b0;
  localparam master_sel_t MST_S01 = 1'b1;
endpackage

// File: rtl/wr_resp_router_1_2_if.sv
// B-channel bundle between one slave port and the two master ports of the write side.
interface wr_resp_router_1_2_if;
    // Every channel here: a beat moves on the rising edge where valid && ready;
    // once valid is high it stays high, with its payload unchanged, until that edge.
    axi_ic_pkg::resp_t M_AXI_bresp;
    logic              M_AXI_bvalid;
    logic              M_AXI_bready;
    axi_ic_pkg::resp_t S00_AXI_bresp;
    logic              S00_AXI_bvalid;
    logic              S00_AXI_bready;
    axi_ic_pkg::resp_t S01_AXI_bresp;
    logic              S01_AXI_bvalid;
    logic              S01_AXI_bready;

    modport master (
        output M_AXI_bresp, M_AXI_bvalid, S00_AXI_bready, S01_AXI_bready,
        input  M_AXI_bready, S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid
    );

    modport slave (
        input  M_AXI_bresp, M_AXI_bvalid, S00_AXI_bready, S01_AXI_bready,
        output M_AXI_bready, S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid
    );
endinterface

// File: rtl/wr_resp_router_1_2_b_owner_fifo.sv
// In-order FIFO of write owners; DEPTH must be a power of two so pointers wrap naturally.
module b_owner_fifo
    import axi_ic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  master_sel_t   push_data,
    input  logic          pop,
    output master_sel_t   pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    master_sel_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wr_resp_router_1_2.sv
// Write-response return path: tracks AW owners in order and steers each slave B
// beat to its owner through a single registered output stage.
module wr_resp_router_1_2
    import axi_ic_pkg::*;
#(
    parameter int Max_Outstanding = 4,
    parameter int Cnt_Width       = $clog2(Max_Outstanding + 1)
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 AW_Push,
    input  master_sel_t          AW_Master,
    output logic                 AW_Allow,
    output logic [Cnt_Width-1:0] Outstanding_Count,
    output logic                 Err_Overflow,
    wr_resp_router_1_2_if.slave  b
);
    master_sel_t head_owner;
    logic        fifo_full;
    logic        fifo_empty;
    logic        out_valid;
    resp_t       out_resp;
    master_sel_t out_owner;
    logic        out_accept;
    logic        slave_ready;
    logic        slave_beat;

    b_owner_fifo #(
        .DEPTH (Max_Outstanding),
        .CW    (Cnt_Width)
    ) u_owner_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .push      (AW_Push),
        .push_data (AW_Master),
        .pop       (slave_beat),
        .pop_data  (head_owner),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (Outstanding_Count)
    );

    // Only the owning master's bready can release the stage.
    assign out_accept  = out_valid &&
                         ((out_owner == MST_S01) ? b.S01_AXI_bready : b.S00_AXI_bready);
    assign slave_ready = !fifo_empty && (!out_valid || out_accept);
    assign slave_beat  = b.M_AXI_bvalid && slave_ready;

    assign AW_Allow       = !fifo_full;
    assign b.M_AXI_bready = slave_ready;

    assign b.S00_AXI_bvalid = out_valid && (out_owner == MST_S00);
    assign b.S01_AXI_bvalid = out_valid && (out_owner == MST_S01);
    assign b.S00_AXI_bresp  = (out_owner == MST_S00) ? out_resp : RESP_OKAY;
    assign b.S01_AXI_bresp  = (out_owner == MST_S01) ? out_resp : RESP_OKAY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_valid <= 1'b0;
            out_resp  <= RESP_OKAY;
            out_owner <= MST_S00;
        end else if (slave_beat) begin
            out_valid <= 1'b1;
            out_resp  <= b.M_AXI_bresp;
            out_owner <= head_owner;
        end else if (out_accept) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                  Err_Overflow <= 1'b0;
        else if (AW_Push && fifo_full) Err_Overflow <= 1'b1;
    end
endmodule

// File: tb/tb_wr_resp_router_1_2.sv
// Bench for wr_resp_router_1_2: directed scenarios plus random traffic against a queue model.
module tb_wr_resp_router_1_2;
  import axi_ic_pkg::*;

  localparam int MAX = 4;
  localparam int CW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          aw_push;
  master_sel_t   aw_master;
  logic          aw_allow;
  logic [CW-1:0] cnt;
  logic          err;

  wr_resp_router_1_2_if bif ();

  wr_resp_router_1_2 #(.Max_Outstanding(MAX)) dut (
    .ACLK              (clk),
    .ARESETN           (rst_n),
    .AW_Push           (aw_push),
    .AW_Master         (aw_master),
    .AW_Allow          (aw_allow),
    .Outstanding_Count (cnt),
    .Err_Overflow      (err),
    .b                 (bif)
  );

  // ---------------- model state ----------------
  master_sel_t owner_q[$];   // owners awaiting a B beat, oldest first
  logic        m_valid;      // a response is waiting at a master
  master_sel_t m_owner;
  resp_t       m_resp;
  logic        m_err;
  logic [2:0]  exp_q[$];     // {owner, resp} in the order masters must receive them
  int          delivered;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    owner_q.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_owner = MST_S00;
    m_resp  = RESP_OKAY;
    m_err   = 1'b0;
  endtask

  task automatic idle_inputs();
    aw_push            = 1'b0;
    aw_master          = MST_S00;
    bif.M_AXI_bvalid   = 1'b0;
    bif.M_AXI_bresp    = RESP_OKAY;
    bif.S00_AXI_bready = 1'b0;
    bif.S01_AXI_bready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s00_bvalid"}, bif.S00_AXI_bvalid, 0);
    check({tag, "_s01_bvalid"}, bif.S01_AXI_bvalid, 0);
    check({tag, "_count"},      cnt, 0);
    check({tag, "_aw_allow"},   aw_allow, 1);
    check({tag, "_m_bready"},   bif.M_AXI_bready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_values("reset");
    check("reset_s00_bresp", bif.S00_AXI_bresp, RESP_OKAY);
    check("reset_s01_bresp", bif.S01_AXI_bresp, RESP_OKAY);
    check("reset_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver + per-cycle compare against the model ----------------
  task automatic cyc(input logic push, input master_sel_t mst, input logic bv,
                     input resp_t br, input logic r0, input logic r1);
    logic        acc, exp_ready, beat;
    int          size_before;
    master_sel_t front;
    logic [2:0]  got, want;
    @(negedge clk);
    aw_push            = push;
    aw_master          = mst;
    bif.M_AXI_bvalid   = bv;
    bif.M_AXI_bresp    = br;
    bif.S00_AXI_bready = r0;
    bif.S01_AXI_bready = r1;
    #1;
    acc       = m_valid && ((m_owner == MST_S01) ? r1 : r0);
    exp_ready = (owner_q.size() != 0) && (!m_valid || acc);
    check("aw_allow", aw_allow, (owner_q.size() != MAX));
    check("count", cnt, owner_q.size());
    check("err_overflow", err, m_err);
    check("m_bready", bif.M_AXI_bready, exp_ready);
    check("s00_bvalid", bif.S00_AXI_bvalid, m_valid && (m_owner == MST_S00));
    check("s01_bvalid", bif.S01_AXI_bvalid, m_valid && (m_owner == MST_S01));
    if (m_valid && m_owner == MST_S00) check("s00_bresp", bif.S00_AXI_bresp, m_resp);
    if (m_valid && m_owner == MST_S01) check("s01_bresp", bif.S01_AXI_bresp, m_resp);

    // delivery scoreboard: every master handshake must match the next expected beat
    for (int m = 0; m < 2; m++) begin
      logic v, r;
      resp_t rs;
      v  = (m == 0) ? bif.S00_AXI_bvalid : bif.S01_AXI_bvalid;
      r  = (m == 0) ? r0 : r1;
      rs = (m == 0) ? bif.S00_AXI_bresp : bif.S01_AXI_bresp;
      if (v && r) begin
        got = {m[0], rs};
        if (exp_q.size() == 0) check("delivery_unexpected", got, 3'h0);
        else begin
          want = exp_q.pop_front();
          check("delivery", got, want);
        end
        delivered++;
      end
    end

    // advance the model to the state after this clock edge
    size_before = owner_q.size();
    beat        = bv && exp_ready;
    if (beat) begin
      front   = owner_q.pop_front();
      m_valid = 1'b1;
      m_owner = front;
      m_resp  = br;
      exp_q.push_back({front, br});
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (push) begin
      if (size_before < MAX) owner_q.push_back(mst);
      else m_err = 1'b1;
    end
  endtask

  task automatic idle_cyc(input logic r0, input logic r1);
    cyc(1'b0, MST_S00, 1'b0, RESP_OKAY, r0, r1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int d0;
    rst_n     = 1'b0;
    delivered = 0;
    idle_inputs();
    clear_model();

    // order: owners 0,1,1 with OKAY, SLVERR, OKAY
    do_reset();
    cyc(1, MST_S00, 0, RESP_OKAY, 1, 1);
    cyc(1, MST_S01, 0, RESP_OKAY, 1, 1);
    cyc(1, MST_S01, 0, RESP_OKAY, 1, 1);
    cyc(0, MST_S00, 1, RESP_OKAY, 1, 1);
    check("order_bready_first", bif.M_AXI_bready, 1);
    cyc(0, MST_S00, 1, RESP_SLVERR, 1, 1);
    check("order_s00_valid", bif.S00_AXI_bvalid, 1);
    check("order_s00_resp", bif.S00_AXI_bresp, RESP_OKAY);
    check("order_s01_idle", bif.S01_AXI_bvalid, 0);
    cyc(0, MST_S00, 1, RESP_OKAY, 1, 1);
    check("order_s01_valid1", bif.S01_AXI_bvalid, 1);
    check("order_s01_resp1", bif.S01_AXI_bresp, RESP_SLVERR);
    idle_cyc(1, 1);
    check("order_s01_valid2", bif.S01_AXI_bvalid, 1);
    check("order_s01_resp2", bif.S01_AXI_bresp, RESP_OKAY);
    idle_cyc(1, 1);
    check("order_drained", bif.S01_AXI_bvalid | bif.S00_AXI_bvalid, 0);

    // full: four pushes close AW, a fifth is dropped and flagged, one pop reopens
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, master_sel_t'(i[0]), 0, RESP_OKAY, 1, 1);
    cyc(1, MST_S01, 0, RESP_OKAY, 1, 1);
    check("full_allow", aw_allow, 0);
    check("full_count", cnt, 4);
    cyc(0, MST_S00, 1, RESP_DECERR, 1, 1);
    check("full_err", err, 1);
    check("full_count_kept", cnt, 4);
    check("full_pop_ready", bif.M_AXI_bready, 1);
    idle_cyc(1, 1);
    check("full_reopen", aw_allow, 1);
    check("full_count_after_pop", cnt, 3);
    for (int i = 0; i < 5; i++) cyc(0, MST_S00, 1, RESP_EXOKAY, 1, 1);
    check("full_err_sticky", err, 1);

    // empty: slave bvalid with nothing tracked is not accepted; push in N pops in N+1
    do_reset();
    cyc(0, MST_S00, 1, RESP_SLVERR, 1, 1);
    check("empty_bready", bif.M_AXI_bready, 0);
    cyc(1, MST_S01, 1, RESP_SLVERR, 1, 1);
    check("empty_no_bypass", bif.M_AXI_bready, 0);
    cyc(0, MST_S00, 1, RESP_SLVERR, 1, 1);
    check("empty_next_cycle", bif.M_AXI_bready, 1);
    idle_cyc(1, 1);
    check("empty_s01_valid", bif.S01_AXI_bvalid, 1);
    check("empty_s01_resp", bif.S01_AXI_bresp, RESP_SLVERR);

    // backpressure: S01 stalls with a second beat pending; S00 ready is ignored
    do_reset();
    cyc(1, MST_S01, 0, RESP_OKAY, 1, 0);
    cyc(1, MST_S00, 0, RESP_OKAY, 1, 0);
    cyc(0, MST_S00, 1, RESP_SLVERR, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, MST_S00, 1, RESP_OKAY, 1, 0);
      check("bp_m_bready", bif.M_AXI_bready, 0);
      check("bp_s01_resp", bif.S01_AXI_bresp, RESP_SLVERR);
      check("bp_s00_valid", bif.S00_AXI_bvalid, 0);
    end
    cyc(0, MST_S00, 1, RESP_OKAY, 1, 1);
    check("bp_release", bif.M_AXI_bready, 1);
    idle_cyc(1, 1);
    check("bp_s00_valid_after", bif.S00_AXI_bvalid, 1);
    check("bp_s00_resp_after", bif.S00_AXI_bresp, RESP_OKAY);

    // throughput: four beats in four consecutive cycles
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, master_sel_t'(i[0]), 0, RESP_OKAY, 1, 1);
    d0 = delivered;
    for (int i = 0; i < 4; i++) begin
      cyc(0, MST_S00, 1, resp_t'($urandom_range(0, 3)), 1, 1);
      check("tput_bready", bif.M_AXI_bready, 1);
    end
    idle_cyc(1, 1);
    check("tput_delivered", delivered - d0, 4);
    check("tput_count", cnt, 0);

    // random traffic with an asynchronous reset dropped in mid-stream
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        @(negedge clk);
        #2;
        bif.M_AXI_bvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        clear_model();
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      cyc(($urandom_range(0, 99) < 45), master_sel_t'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 60), resp_t'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70));
    end
    for (int i = 0; i < 12; i++) cyc(0, MST_S00, 1, RESP_OKAY, 1, 1);
    check("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
